// File: rtl/axil_rd_arbiter.sv
// Round-robin arbiter that shares one AXI-Lite read slave among NUM_M masters,
// with one transaction in flight and a DATA-phase timeout that answers SLVERR.
module axil_rd_arbiter #(
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int C_AXI_ADDR_WIDTH = 8,
  parameter int NUM_M            = 2,
  parameter int TIMEOUT          = 16
) (
  input  logic                              AXI_ACLK,
  input  logic                              AXI_ARESET,
  input  logic [NUM_M*C_AXI_ADDR_WIDTH-1:0] M_ARADDR,
  input  logic [NUM_M-1:0]                  M_ARVALID,
  output logic [NUM_M-1:0]                  M_ARREADY,
  output logic [C_AXI_DATA_WIDTH-1:0]       M_RDATA,
  output logic [1:0]                        M_RRESP,
  output logic [NUM_M-1:0]                  M_RVALID,
  input  logic [NUM_M-1:0]                  M_RREADY,
  output logic [C_AXI_ADDR_WIDTH-1:0]       S_ARADDR,
  output logic                              S_ARVALID,
  input  logic                              S_ARREADY,
  input  logic [C_AXI_DATA_WIDTH-1:0]       S_RDATA,
  input  logic [1:0]                        S_RRESP,
  input  logic                              S_RVALID,
  output logic                              S_RREADY,
  output logic [NUM_M-1:0]                  GRANT,
  output logic                              BUSY
);

  localparam int IDX_W = (NUM_M > 1) ? $clog2(NUM_M) : 1;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  logic [1:0]                  state;
  logic [IDX_W-1:0]            last;
  logic [NUM_M-1:0]            grant;
  logic [C_AXI_ADDR_WIDTH-1:0] addr_r;
  logic [C_AXI_DATA_WIDTH-1:0] rdata_r;
  logic [1:0]                  rresp_r;
  logic [CNT_W-1:0]            cnt;

  logic [IDX_W-1:0]            win;
  logic                        any_req;
  logic                        owner_rready;

  // First requester found searching upward from the slot after the last owner.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_M-1:0] req,
                                               input logic [IDX_W-1:0] prev);
    logic [IDX_W-1:0] pick;
    int               idx;
    pick = prev;
    for (int i = NUM_M; i >= 1; i--) begin
      idx = (int'(prev) + i) % NUM_M;
      if (req[idx]) pick = IDX_W'(idx);
    end
    return pick;
  endfunction

  assign any_req      = |M_ARVALID;
  assign win          = rr_pick(M_ARVALID, last);
  assign owner_rready = |(M_RREADY & grant);

  always_ff @(posedge AXI_ACLK) begin
    if (AXI_ARESET) begin
      state   <= ST_IDLE;
      last    <= IDX_W'(NUM_M - 1);
      grant   <= '0;
      addr_r  <= '0;
      rdata_r <= '0;
      rresp_r <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            grant  <= NUM_M'(1) << win;
            addr_r <= M_ARADDR[int'(win)*C_AXI_ADDR_WIDTH +: C_AXI_ADDR_WIDTH];
            state  <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          cnt <= '0;
          if (S_ARREADY) state <= ST_DATA;
        end
        ST_DATA: begin
          // Slave data takes priority even in the final timeout cycle.
          if (S_RVALID) begin
            rdata_r <= S_RDATA;
            rresp_r <= S_RRESP;
            state   <= ST_RESP;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            rdata_r <= '0;
            rresp_r <= 2'b10;
            state   <= ST_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RESP: begin
          if (owner_rready) begin
            for (int i = 0; i < NUM_M; i++) begin
              if (grant[i]) last <= IDX_W'(i);
            end
            grant <= '0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Outputs are forced low whenever reset is sampled, whatever the state.
  always_comb begin
    M_ARREADY = '0;
    M_RVALID  = '0;
    S_ARVALID = 1'b0;
    S_ARADDR  = '0;
    S_RREADY  = 1'b0;
    M_RDATA   = '0;
    M_RRESP   = '0;
    GRANT     = '0;
    BUSY      = 1'b0;
    if (!AXI_ARESET) begin
      M_RDATA = rdata_r;
      M_RRESP = rresp_r;
      GRANT   = grant;
      BUSY    = (state != ST_IDLE);
      case (state)
        ST_IDLE: begin
          S_RREADY = 1'b1;
          if (any_req) M_ARREADY = NUM_M'(1) << win;
        end
        ST_ADDR: begin
          S_ARVALID = 1'b1;
          S_ARADDR  = addr_r;
        end
        ST_DATA: S_RREADY = 1'b1;
        ST_RESP: M_RVALID = grant;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_rd_arbiter.sv
// Directed scenarios plus a randomized transaction run scored against a
// transaction-level model of the arbiter.
module tb_axil_rd_arbiter;

  localparam int NM = 2;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int TO = 16;

  logic              AXI_ACLK = 1'b0;
  logic              AXI_ARESET;
  logic [NM*AW-1:0]  M_ARADDR;
  logic [NM-1:0]     M_ARVALID;
  logic [NM-1:0]     M_ARREADY;
  logic [DW-1:0]     M_RDATA;
  logic [1:0]        M_RRESP;
  logic [NM-1:0]     M_RVALID;
  logic [NM-1:0]     M_RREADY;
  logic [AW-1:0]     S_ARADDR;
  logic              S_ARVALID;
  logic              S_ARREADY;
  logic [DW-1:0]     S_RDATA;
  logic [1:0]        S_RRESP;
  logic              S_RVALID;
  logic              S_RREADY;
  logic [NM-1:0]     GRANT;
  logic              BUSY;

  int checks = 0;
  int errors = 0;
  int last_m;

  axil_rd_arbiter #(
    .C_AXI_DATA_WIDTH(DW), .C_AXI_ADDR_WIDTH(AW), .NUM_M(NM), .TIMEOUT(TO)
  ) dut (
    .AXI_ACLK(AXI_ACLK), .AXI_ARESET(AXI_ARESET),
    .M_ARADDR(M_ARADDR), .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
    .M_RDATA(M_RDATA), .M_RRESP(M_RRESP), .M_RVALID(M_RVALID), .M_RREADY(M_RREADY),
    .S_ARADDR(S_ARADDR), .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
    .S_RDATA(S_RDATA), .S_RRESP(S_RRESP), .S_RVALID(S_RVALID), .S_RREADY(S_RREADY),
    .GRANT(GRANT), .BUSY(BUSY)
  );

  always #5 AXI_ACLK = ~AXI_ACLK;

  // Model: next owner is the first requester after the previous owner, cyclically.
  function automatic int model_winner(input logic [NM-1:0] req, input int prev);
    for (int off = 1; off <= NM; off++) begin
      if (req[(prev + off) % NM]) return (prev + off) % NM;
    end
    return -1;
  endfunction

  function automatic logic [NM-1:0] onehot(input int idx);
    logic [NM-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  task automatic idle_inputs();
    M_ARVALID = '0; M_RREADY = '0; S_ARREADY = 1'b0;
    S_RVALID = 1'b0; S_RDATA = '0; S_RRESP = '0;
  endtask

  task automatic apply_reset();
    @(negedge AXI_ACLK); AXI_ARESET = 1'b1; idle_inputs();
    @(negedge AXI_ACLK); AXI_ARESET = 1'b0;
    last_m = NM - 1;
  endtask

  task automatic test_reset();
    AXI_ARESET = 1'b1;
    M_ARVALID = 2'b11; M_ARADDR = 16'h2211; M_RREADY = 2'b11;
    S_ARREADY = 1'b1; S_RVALID = 1'b1; S_RDATA = 32'h12345678; S_RRESP = 2'b01;
    for (int c = 0; c < 2; c++) begin
      @(negedge AXI_ACLK); #1;
      checks++;
      if ({M_ARREADY, M_RVALID, S_ARVALID, S_RREADY, GRANT, BUSY} !== '0) begin
        errors++;
        $display("FAIL reset_ctrl cyc=%0d got arready=%b rvalid=%b sarvalid=%b srready=%b grant=%b busy=%b exp all 0",
                 c, M_ARREADY, M_RVALID, S_ARVALID, S_RREADY, GRANT, BUSY);
      end
      checks++;
      if ({M_RDATA, M_RRESP, S_ARADDR} !== '0) begin
        errors++;
        $display("FAIL reset_data cyc=%0d got rdata=%h rresp=%b saraddr=%h exp 0", c, M_RDATA, M_RRESP, S_ARADDR);
      end
    end
    @(negedge AXI_ACLK); AXI_ARESET = 1'b0; idle_inputs();
    #1;
    checks++;
    if (BUSY !== 1'b0 || GRANT !== '0 || S_RREADY !== 1'b1) begin
      errors++;
      $display("FAIL reset_release got busy=%b grant=%b srready=%b exp 0/00/1", BUSY, GRANT, S_RREADY);
    end
    last_m = NM - 1;
  endtask

  task automatic test_single();
    logic seen1;
    seen1 = 1'b0;
    @(negedge AXI_ACLK);
    M_ARVALID = 2'b01; M_ARADDR = {8'h77, 8'h10}; S_ARREADY = 1'b1; M_RREADY = 2'b01;
    #1; seen1 |= M_ARREADY[1];
    checks++;
    if (M_ARREADY !== 2'b01) begin errors++; $display("FAIL single_t0_arready got=%b exp=01", M_ARREADY); end
    @(negedge AXI_ACLK); M_ARVALID = 2'b00; #1; seen1 |= M_ARREADY[1];
    checks++;
    if (S_ARVALID !== 1'b1 || S_ARADDR !== 8'h10) begin
      errors++; $display("FAIL single_t1_addr got arvalid=%b addr=%h exp 1/10", S_ARVALID, S_ARADDR);
    end
    checks++;
    if (GRANT !== 2'b01) begin errors++; $display("FAIL single_t1_grant got=%b exp=01", GRANT); end
    @(negedge AXI_ACLK); S_RVALID = 1'b1; S_RDATA = 32'hDEADBEEF; S_RRESP = 2'b00; #1; seen1 |= M_ARREADY[1];
    checks++;
    if (S_RREADY !== 1'b1 || S_ARVALID !== 1'b0 || M_RVALID !== '0) begin
      errors++; $display("FAIL single_t2_data got srready=%b sarvalid=%b rvalid=%b exp 1/0/00", S_RREADY, S_ARVALID, M_RVALID);
    end
    @(negedge AXI_ACLK); S_RVALID = 1'b0; S_RDATA = '0; #1; seen1 |= M_ARREADY[1];
    checks++;
    if (M_RVALID !== 2'b01 || M_RDATA !== 32'hDEADBEEF || M_RRESP !== 2'b00) begin
      errors++; $display("FAIL single_t3_resp got rvalid=%b rdata=%h rresp=%b exp 01/deadbeef/00", M_RVALID, M_RDATA, M_RRESP);
    end
    @(negedge AXI_ACLK); M_RREADY = '0; #1; seen1 |= M_ARREADY[1];
    checks++;
    if (BUSY !== 1'b0 || GRANT !== '0 || M_RVALID !== '0) begin
      errors++; $display("FAIL single_done got busy=%b grant=%b rvalid=%b exp 0/00/00", BUSY, GRANT, M_RVALID);
    end
    checks++;
    if (seen1 !== 1'b0) begin errors++; $display("FAIL single_arready1 got=1 exp=never"); end
    last_m = 0;
  endtask

  task automatic test_contention();
    logic [NM-1:0] g [4];
    int            stamp [4];
    int            n;
    int            exp_w;
    apply_reset();
    n = 0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      @(negedge AXI_ACLK);
      M_ARVALID = 2'b11; M_RREADY = 2'b11; S_ARREADY = 1'b1;
      S_RVALID = 1'b1; S_RDATA = 32'(c); S_RRESP = 2'b00;
      #1;
      if (M_ARREADY !== '0) begin g[n] = M_ARREADY; stamp[n] = c; n++; end
    end
    checks++;
    if (n != 4) begin errors++; $display("FAIL contention_count got=%0d grants exp=4", n); end
    for (int i = 0; i < n; i++) begin
      exp_w = model_winner(2'b11, last_m);
      checks++;
      if (g[i] !== onehot(exp_w)) begin
        errors++; $display("FAIL contention_grant idx=%0d got=%b exp=%b", i, g[i], onehot(exp_w));
      end
      if (i > 0) begin
        checks++;
        if (stamp[i] - stamp[i-1] != 4) begin
          errors++; $display("FAIL contention_gap idx=%0d got=%0d exp=4", i, stamp[i] - stamp[i-1]);
        end
      end
      last_m = exp_w;
    end
    // Finish the transaction granted on the last recorded cycle.
    @(negedge AXI_ACLK); M_ARVALID = '0;
    repeat (3) @(negedge AXI_ACLK);
    idle_inputs(); #1;
    checks++;
    if (BUSY !== 1'b0) begin errors++; $display("FAIL contention_drain got busy=%b exp=0", BUSY); end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] d;
    d = $urandom;
    @(negedge AXI_ACLK);
    M_ARVALID = 2'b01; M_ARADDR = {8'hB1, 8'hA0}; S_ARREADY = 1'b1; M_RREADY = '0; S_RVALID = 1'b0;
    #1;
    checks++;
    if (M_ARREADY !== onehot(model_winner(2'b01, last_m))) begin
      errors++; $display("FAIL bp_grant got=%b exp=01", M_ARREADY);
    end
    @(negedge AXI_ACLK); M_ARVALID = 2'b10;
    @(negedge AXI_ACLK); S_RVALID = 1'b1; S_RDATA = d; S_RRESP = 2'b01;
    @(negedge AXI_ACLK); S_RVALID = 1'b0; S_RDATA = ~d; M_RREADY = 2'b10;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge AXI_ACLK);
      #1;
      checks++;
      if (M_RVALID !== 2'b01 || M_RDATA !== d || M_RRESP !== 2'b01) begin
        errors++; $display("FAIL bp_hold cyc=%0d got rvalid=%b rdata=%h rresp=%b exp 01/%h/01", i, M_RVALID, M_RDATA, M_RRESP, d);
      end
      checks++;
      if (S_ARVALID !== 1'b0 || M_ARREADY !== '0 || GRANT !== 2'b01) begin
        errors++; $display("FAIL bp_nogrant cyc=%0d got sarvalid=%b arready=%b grant=%b exp 0/00/01", i, S_ARVALID, M_ARREADY, GRANT);
      end
    end
    @(negedge AXI_ACLK); M_RREADY = 2'b01;
    last_m = 0;
    @(negedge AXI_ACLK); M_RREADY = '0; #1;
    checks++;
    if (M_ARREADY !== onehot(model_winner(2'b10, last_m)) || M_RVALID !== '0) begin
      errors++; $display("FAIL bp_next got arready=%b rvalid=%b exp 10/00", M_ARREADY, M_RVALID);
    end
    @(negedge AXI_ACLK); M_ARVALID = '0;
    @(negedge AXI_ACLK); S_RVALID = 1'b1; S_RDATA = 32'hCAFE0001; S_RRESP = 2'b00;
    @(negedge AXI_ACLK); S_RVALID = 1'b0; M_RREADY = 2'b10; #1;
    checks++;
    if (M_RVALID !== 2'b10 || M_RDATA !== 32'hCAFE0001) begin
      errors++; $display("FAIL bp_m1_resp got rvalid=%b rdata=%h exp 10/cafe0001", M_RVALID, M_RDATA);
    end
    @(negedge AXI_ACLK); idle_inputs();
    last_m = 1;
  endtask

  task automatic test_timeout();
    int  n;
    logic done;
    @(negedge AXI_ACLK);
    M_ARVALID = 2'b01; M_ARADDR = {8'h00, 8'h44}; S_ARREADY = 1'b1; S_RVALID = 1'b0; M_RREADY = 2'b01;
    @(negedge AXI_ACLK); M_ARVALID = '0;
    n = 0; done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge AXI_ACLK); #1;
      if (M_RVALID !== '0) done = 1'b1;
      else n++;
    end
    checks++;
    if (!done || n != TO) begin errors++; $display("FAIL timeout_cycles got=%0d done=%b exp=%0d", n, done, TO); end
    checks++;
    if (M_RVALID !== 2'b01 || M_RRESP !== 2'b10 || M_RDATA !== '0) begin
      errors++; $display("FAIL timeout_resp got rvalid=%b rresp=%b rdata=%h exp 01/10/0", M_RVALID, M_RRESP, M_RDATA);
    end
    last_m = 0;
    @(negedge AXI_ACLK); M_RREADY = '0; S_RVALID = 1'b1; S_RDATA = 32'h0BAD0BAD; S_RRESP = 2'b00; #1;
    checks++;
    if (S_RREADY !== 1'b1 || M_RVALID !== '0) begin
      errors++; $display("FAIL timeout_late_idle got srready=%b rvalid=%b exp 1/00", S_RREADY, M_RVALID);
    end
    @(negedge AXI_ACLK); S_RVALID = 1'b0; #1;
    checks++;
    if (M_RVALID !== '0 || BUSY !== 1'b0 || M_RDATA === 32'h0BAD0BAD) begin
      errors++; $display("FAIL timeout_discard got rvalid=%b busy=%b rdata=%h exp 00/0/not 0bad0bad", M_RVALID, BUSY, M_RDATA);
    end
  endtask

  task automatic test_midop_reset();
    @(negedge AXI_ACLK);
    M_ARVALID = 2'b10; S_ARREADY = 1'b1; S_RVALID = 1'b0; M_RREADY = 2'b11;
    #1;
    checks++;
    if (M_ARREADY !== onehot(model_winner(2'b10, last_m))) begin
      errors++; $display("FAIL midop_grant got=%b exp=10", M_ARREADY);
    end
    @(negedge AXI_ACLK); M_ARVALID = '0;
    @(negedge AXI_ACLK);
    @(negedge AXI_ACLK); AXI_ARESET = 1'b1; #1;
    checks++;
    if (BUSY !== 1'b0 || S_RREADY !== 1'b0 || GRANT !== '0) begin
      errors++; $display("FAIL midop_in_reset got busy=%b srready=%b grant=%b exp 0/0/00", BUSY, S_RREADY, GRANT);
    end
    last_m = NM - 1;
    @(negedge AXI_ACLK); AXI_ARESET = 1'b0; #1;
    checks++;
    if (BUSY !== 1'b0 || M_RVALID !== '0 || S_ARVALID !== 1'b0 || GRANT !== '0) begin
      errors++; $display("FAIL midop_after got busy=%b rvalid=%b sarvalid=%b grant=%b exp all 0", BUSY, M_RVALID, S_ARVALID, GRANT);
    end
    @(negedge AXI_ACLK); M_ARVALID = 2'b11; #1;
    checks++;
    if (M_ARREADY !== onehot(model_winner(2'b11, last_m))) begin
      errors++; $display("FAIL midop_first got=%b exp=%b", M_ARREADY, onehot(model_winner(2'b11, last_m)));
    end
    @(negedge AXI_ACLK); M_ARVALID = '0;
  endtask

  task automatic test_random();
    logic [NM-1:0] req;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_data;
    logic [1:0]    exp_resp;
    logic [NM-1:0] mr;
    int            w, arw, d, rw, lim;
    apply_reset();
    for (int t = 0; t < 40; t++) begin
      @(negedge AXI_ACLK);
      req = NM'($urandom_range(1, (1 << NM) - 1));
      M_ARVALID = req; M_ARADDR = NM*AW'($urandom);
      S_ARREADY = 1'b0; S_RVALID = 1'b0; M_RREADY = NM'($urandom);
      w = model_winner(req, last_m);
      exp_addr = M_ARADDR[w*AW +: AW];
      #1;
      checks++;
      if (M_ARREADY !== onehot(w) || BUSY !== 1'b0) begin
        errors++; $display("FAIL rnd_grant txn=%0d got arready=%b busy=%b exp %b/0", t, M_ARREADY, BUSY, onehot(w));
      end
      arw = $urandom_range(0, 3);
      for (int k = 0; k <= arw; k++) begin
        @(negedge AXI_ACLK);
        S_ARREADY = (k == arw); M_ARVALID = NM'($urandom); M_ARADDR = NM*AW'($urandom);
        #1;
        checks++;
        if (S_ARVALID !== 1'b1 || S_ARADDR !== exp_addr || M_ARREADY !== '0 || S_RREADY !== 1'b0) begin
          errors++; $display("FAIL rnd_addr txn=%0d got sarvalid=%b addr=%h arready=%b srready=%b exp 1/%h/00/0",
                             t, S_ARVALID, S_ARADDR, M_ARREADY, S_RREADY, exp_addr);
        end
      end
      d = $urandom_range(0, TO + 2);
      lim = (d < TO) ? d : TO - 1;
      exp_data = '0; exp_resp = 2'b10;
      for (int k = 0; k <= lim; k++) begin
        @(negedge AXI_ACLK);
        S_ARREADY = 1'b0; S_RVALID = (k == d); S_RDATA = $urandom; S_RRESP = 2'($urandom);
        M_ARVALID = NM'($urandom);
        if (k == d) begin exp_data = S_RDATA; exp_resp = S_RRESP; end
        #1;
        checks++;
        if (S_RREADY !== 1'b1 || M_RVALID !== '0 || S_ARVALID !== 1'b0) begin
          errors++; $display("FAIL rnd_data txn=%0d k=%0d got srready=%b rvalid=%b sarvalid=%b exp 1/00/0", t, k, S_RREADY, M_RVALID, S_ARVALID);
        end
      end
      rw = $urandom_range(0, 3);
      for (int k = 0; k <= rw; k++) begin
        @(negedge AXI_ACLK);
        S_RVALID = 1'b0; M_ARVALID = NM'($urandom);
        mr = NM'($urandom); mr[w] = (k == rw); M_RREADY = mr;
        #1;
        checks++;
        if (M_RVALID !== onehot(w) || M_RDATA !== exp_data || M_RRESP !== exp_resp ||
            GRANT !== onehot(w) || M_ARREADY !== '0 || S_RREADY !== 1'b0) begin
          errors++; $display("FAIL rnd_resp txn=%0d d=%0d got rvalid=%b rdata=%h rresp=%b grant=%b arready=%b exp %b/%h/%b",
                             t, d, M_RVALID, M_RDATA, M_RRESP, GRANT, M_ARREADY, onehot(w), exp_data, exp_resp);
        end
      end
      last_m = w;
    end
    @(negedge AXI_ACLK); idle_inputs();
  endtask

  initial begin
    M_ARADDR = '0;
    idle_inputs();
    last_m = NM - 1;
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_timeout();
    test_midop_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axil_rd_arbiter.md
AXIL_RD_ARBITER -- requirements
Module: axil_rd_arbiter

Interface
REQ-001 The block SHALL have one clock, AXI_ACLK, and a synchronous, active-high reset, AXI_ARESET.
REQ-002 Parameters (name, default, meaning) SHALL be:
- C_AXI_DATA_WIDTH, 32, RDATA width.
- C_AXI_ADDR_WIDTH, 8, ARADDR width.
- NUM_M, 2, number of requesting masters (2..8).
- TIMEOUT, 16, maximum DATA-state cycles to wait for slave RVALID (>=2).
REQ-003 Ports (name, direction, width, meaning) SHALL be:
- AXI_ACLK  in  1  clock.
- AXI_ARESET  in  1  synchronous active-high reset.
- M_ARADDR  in  NUM_M*C_AXI_ADDR_WIDTH  packed per-master read addresses; master i occupies slice i.
- M_ARVALID  in  NUM_M  per-master address valid.
- M_ARREADY  out  NUM_M  per-master address accept.
- M_RDATA  out  C_AXI_DATA_WIDTH  shared read data to all masters.
- M_RRESP  out  2  shared read response.
- M_RVALID  out  NUM_M  per-master read valid.
- M_RREADY  in  NUM_M  per-master read ready.
- S_ARADDR  out  C_AXI_ADDR_WIDTH  slave address.
- S_ARVALID  out  1  slave address valid.
- S_ARREADY  in  1  slave address ready.
- S_RDATA  in  C_AXI_DATA_WIDTH  slave read data.
- S_RRESP  in  2  slave read response.
- S_RVALID  in  1  slave read valid.
- S_RREADY  out  1  slave read ready.
- GRANT  out  NUM_M  one-hot current owner; 0 when idle.
- BUSY  out  1  high in every state except IDLE.

Function
REQ-004 The block SHALL be a four-state FSM, IDLE -> ADDR -> DATA -> RESP -> IDLE, with at most one outstanding transaction.
REQ-005 IDLE SHALL behave as follows:
- If any M_ARVALID is high, select the winner by round-robin, searching from index (last+1) mod NUM_M upward.
- In that same cycle, drive M_ARREADY[winner]=1, latch M_ARADDR slice and GRANT, and go to ADDR.
- Assert no other M_ARREADY bit.
REQ-006 ADDR SHALL drive S_ARVALID=1 and S_ARADDR=latched address, holding both stable until S_ARREADY, then go to DATA.
REQ-007 DATA SHALL behave as follows:
- Drive S_RREADY=1.
- On S_RVALID, register S_RDATA/S_RRESP and go to RESP.
REQ-008 DATA SHALL count cycles from 0. If the count reaches TIMEOUT-1 without S_RVALID, it SHALL register RDATA=0, RRESP=2'b10 (SLVERR) and go to RESP. If S_RVALID arrives in the timeout cycle, slave data SHALL win.
REQ-009 RESP SHALL behave as follows:
- Drive M_RVALID[owner]=1, with M_RDATA/M_RRESP from the register.
- Hold all three stable until M_RREADY[owner].
- On that handshake, set last=owner, clear GRANT, and go to IDLE.
REQ-010 S_RREADY SHALL also be 1 in IDLE. A slave beat accepted in IDLE (late after a timeout) SHALL be discarded and SHALL NOT reach any master.
REQ-011 S_RREADY SHALL be 0 in ADDR and RESP, and S_ARVALID SHALL be 0 outside ADDR.
REQ-012 M_RREADY of non-owners SHALL be ignored, and M_ARVALID SHALL be ignored outside IDLE.
REQ-013 Minimum latency SHALL be three cycles from M_ARVALID to M_RVALID, with zero-wait slave: grant at T0, S_ARVALID at T1, DATA at T2, M_RVALID at T3.
REQ-014 A new grant SHALL NOT occur in the cycle RESP completes; the next arbitration SHALL occur in IDLE one cycle later.

Reset
REQ-015 While AXI_ARESET=1 at a clock edge, the block SHALL do the following, regardless of current state:
- Set state=IDLE and clear the timeout counter.
- Set last=NUM_M-1, so master 0 wins first.
- Set all outputs to 0, including S_RREADY, GRANT, BUSY, M_RDATA and M_RRESP.
REQ-016 A reset asserted mid-transaction SHALL abandon the transaction with no response to the master. In the first cycle after reset release, S_ARVALID=0 and M_RVALID=0.

Verification
REQ-017 The bench SHALL cover the following directed scenarios:
- Reset: hold AXI_ARESET=1 2 cycles -> all outputs 0, BUSY=0, GRANT=0.
- Single read: M_ARVALID[0]=1, addr 0x10, S_ARREADY=1, S_RVALID at T2 with 0xDEADBEEF, RRESP=0 -> at T3 M_RVALID=2'b01, M_RDATA=0xDEADBEEF, M_RRESP=0; S_ARADDR=0x10 at T1; M_ARREADY[1] never 1.
- Contention: M_ARVALID=2'b11 continuously, M_RREADY=2'b11 -> GRANT sequence 01,10,01,10.
- Backpressure: M_RREADY[0]=0 for 4 cycles in RESP -> M_RVALID, M_RDATA stable 4 cycles; S_ARVALID=0 and no new grant while M_ARVALID[1]=1.
- Timeout: slave never asserts S_RVALID, TIMEOUT=16 -> M_RVALID after 16 DATA cycles with M_RRESP=2'b10, M_RDATA=0. A later S_RVALID in IDLE is consumed and not forwarded.
- Mid-op reset: AXI_ARESET=1 for 1 cycle in DATA -> IDLE next cycle, no M_RVALID; the next request from master 0 is granted first.
